collision_event_unit: RTL



---
 rtl/collision_event_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/collision_event_unit.sv
// Pairwise drawing-request collision detector with per-frame summaries and an event FIFO.
// Define CEU_FRAME_STAMP_EN to tag each queued event with an 8-bit frame number.
module collision_event_unit #(
    parameter int                           NUM_OBJ    = 8,
    parameter logic [NUM_OBJ*NUM_OBJ-1:0]   PAIR_MASK  = '1,
    parameter int                           FIFO_DEPTH = 8,
    parameter int                           IDW        = $clog2(NUM_OBJ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         startOfFrame,
    input  logic [NUM_OBJ-1:0]           dr,
    output logic [NUM_OBJ*NUM_OBJ-1:0]   collision_pulse,
    output logic [NUM_OBJ*NUM_OBJ-1:0]   frame_hits,
    output logic [NUM_OBJ-1:0]           obj_hit,
    output logic                         evt_valid,
    output logic [IDW-1:0]               evt_i,
    output logic [IDW-1:0]               evt_j,
    input  logic                         evt_pop,
    output logic                         evt_overflow
`ifdef CEU_FRAME_STAMP_EN
    ,
    output logic [7:0]                   evt_frame
`endif
);

    localparam int NP = NUM_OBJ * NUM_OBJ;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
`ifdef CEU_FRAME_STAMP_EN
    localparam int SW = 8;
`else
    localparam int SW = 0;
`endif
    localparam int EW = 2 * IDW + SW;

    logic [NP-1:0]      new_hit, sel_onehot;
    logic [NP-1:0]      seen_q, seen_d, pending_q, pending_d;
    logic [NP-1:0]      pulse_q, pulse_d, frame_hits_q, frame_hits_d;
    logic [NUM_OBJ-1:0] obj_hit_q, obj_hit_d, hit_obj;
    logic               overflow_q, overflow_d;
    logic               found, push, pop;
    logic [IDW-1:0]     sel_i, sel_j;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic [EW-1:0]      fifo_q [FIFO_DEPTH];
    logic [EW-1:0]      push_entry;

    // Index i*NUM_OBJ+j grows with (i, j) lexicographically, so the first pending hit is the lowest pair.
    always_comb begin
        new_hit    = '0;
        sel_onehot = '0;
        hit_obj    = '0;
        found      = 1'b0;
        sel_i      = '0;
        sel_j      = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            for (int j = i + 1; j < NUM_OBJ; j++) begin
                new_hit[i*NUM_OBJ+j] = dr[i] & dr[j] & PAIR_MASK[i*NUM_OBJ+j]
                                     & ~seen_q[i*NUM_OBJ+j] & ~startOfFrame;
                if (new_hit[i*NUM_OBJ+j]) begin
                    hit_obj[i] = 1'b1;
                    hit_obj[j] = 1'b1;
                end
                if (pending_q[i*NUM_OBJ+j] && !found) begin
                    found                   = 1'b1;
                    sel_i                   = IDW'(i);
                    sel_j                   = IDW'(j);
                    sel_onehot[i*NUM_OBJ+j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        push         = found && (count_q < CW'(FIFO_DEPTH));
        pop          = evt_pop && (count_q != '0);
        pulse_d      = new_hit;
        seen_d       = startOfFrame ? '0 : (seen_q | new_hit);
        obj_hit_d    = startOfFrame ? '0 : (obj_hit_q | hit_obj);
        frame_hits_d = startOfFrame ? seen_q : frame_hits_q;
        // A repeat hit on a still-pending pair is dropped rather than queued twice.
        overflow_d   = overflow_q | (|(new_hit & pending_q));
        pending_d    = (pending_q & ~(sel_onehot & {NP{push}})) | (new_hit & ~pending_q);
        wr_ptr_d     = wr_ptr_q + PW'(push);
        rd_ptr_d     = rd_ptr_q + PW'(pop);
        count_d      = count_q + CW'(push) - CW'(pop);
    end

`ifdef CEU_FRAME_STAMP_EN
    logic [7:0] frame_cnt_q, frame_cnt_d, sel_stamp;
    logic [7:0] stamp_q [NP];

    always_comb begin
        frame_cnt_d = frame_cnt_q + {7'd0, startOfFrame};
        sel_stamp   = '0;
        for (int k = 0; k < NP; k++)
            sel_stamp = sel_stamp | (stamp_q[k] & {8{sel_onehot[k]}});
        push_entry  = {sel_i, sel_j, sel_stamp};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_q <= '0;
            for (int k = 0; k < NP; k++) stamp_q[k] <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            for (int k = 0; k < NP; k++)
                if (new_hit[k] && !pending_q[k]) stamp_q[k] <= frame_cnt_q;
        end
    end

    assign evt_frame = fifo_q[rd_ptr_q][7:0];
`else
    assign push_entry = {sel_i, sel_j};
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seen_q       <= '0;
            pending_q    <= '0;
            pulse_q      <= '0;
            frame_hits_q <= '0;
            obj_hit_q    <= '0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int k = 0; k < FIFO_DEPTH; k++) fifo_q[k] <= '0;
        end else begin
            seen_q       <= seen_d;
            pending_q    <= pending_d;
            pulse_q      <= pulse_d;
            frame_hits_q <= frame_hits_d;
            obj_hit_q    <= obj_hit_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            if (push) fifo_q[wr_ptr_q] <= push_entry;
        end
    end

    assign collision_pulse = pulse_q;
    assign frame_hits      = frame_hits_q;
    assign obj_hit         = obj_hit_q;
    assign evt_overflow    = overflow_q;
    assign evt_valid       = (count_q != '0);
    assign evt_i           = fifo_q[rd_ptr_q][EW-1 -: IDW];
    assign evt_j           = fifo_q[rd_ptr_q][EW-IDW-1 -: IDW];

endmodule
